// File: rtl/lcd_reader_pkg.sv
// ============================================================================
// Package  : lcd_reader_pkg
// Brief    : Shared definitions for the HD44780 read/write bus sequencers:
//            bus-cycle state encoding, busy-flag bit position, default
//            timing for the 50 MHz DE2 clock, and a small sizing helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package lcd_reader_pkg;

  // Bus-cycle state encoding, shared with the write driver
  localparam int unsigned    c_STATE_W = 3;
  localparam logic [2:0]     IDLE      = 3'd0;
  localparam logic [2:0]     SETUP     = 3'd1;
  localparam logic [2:0]     EN_HI     = 3'd2;
  localparam logic [2:0]     HOLD      = 3'd3;
  localparam logic [2:0]     RECOVER   = 3'd4;

  // Busy flag position in the status byte
  localparam int unsigned    LCD_BF_BIT = 7;

  // Default timing at 50 MHz (20 ns per clock)
  localparam int unsigned    c_DEF_SETUP_CYC   = 2;    // tAS >= 40 ns
  localparam int unsigned    c_DEF_EN_HIGH_CYC = 16;   // PWEH >= 230 ns, covers tDDR
  localparam int unsigned    c_DEF_HOLD_CYC    = 2;    // tAH
  localparam int unsigned    c_DEF_RECOVER_CYC = 10;   // full En cycle >= 500 ns
  localparam int unsigned    c_DEF_MAX_POLLS   = 1024;

  // Largest of the four phase lengths; sizes the shared down-counter
  function automatic int unsigned cyc_max(input int unsigned a, input int unsigned b,
                                          input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_reader_bus_timer.sv
// ============================================================================
// Module   : lcd_bus_timer
// Brief    : Loadable down-counter with a zero flag. Times each bus phase;
//            saturates at zero until reloaded.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lcd_bus_timer #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] value_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Load wins over counting; hold at zero otherwise
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/lcd_reader.sv
// ============================================================================
// Module   : lcd_reader
// Brief    : One HD44780 read cycle (RW=1): status (RS=0) or data (RS=1).
//            Returns the sampled byte with a one-cycle oDone pulse.
//            Optional macro LCD_BUSY_POLL_EN: status reads repeat while the
//            busy flag is set, up to MAX_POLLS reads, then flag oTimeout.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lcd_reader
  import lcd_reader_pkg::*;
#(
  parameter int unsigned SETUP_CYC   = c_DEF_SETUP_CYC,
  parameter int unsigned EN_HIGH_CYC = c_DEF_EN_HIGH_CYC,
  parameter int unsigned HOLD_CYC    = c_DEF_HOLD_CYC,
  parameter int unsigned RECOVER_CYC = c_DEF_RECOVER_CYC,
  parameter int unsigned MAX_POLLS   = c_DEF_MAX_POLLS
) (
  input  logic       iClk,
  input  logic       nRst,
  input  logic       iStart,
  input  logic       iRS,
  output logic       oBusy,
  output logic       oDone,
  output logic [7:0] oData,
  output logic       oTimeout,
  inout  wire  [7:0] LCD_DATA,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_En
);

  localparam int unsigned c_CNT_W = $clog2(cyc_max(SETUP_CYC, EN_HIGH_CYC,
                                                   HOLD_CYC, RECOVER_CYC) + 1);
  // The counter is loaded with N-1 so a phase lasts exactly N clocks
  localparam logic [c_CNT_W-1:0] c_LD_SETUP   = c_CNT_W'(SETUP_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_LD_EN_HI   = c_CNT_W'(EN_HIGH_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_LD_HOLD    = c_CNT_W'(HOLD_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_LD_RECOVER = c_CNT_W'(RECOVER_CYC - 1);

  logic [c_STATE_W-1:0] state_q;
  logic [c_STATE_W-1:0] state_d;
  logic                 rs_q;
  logic [7:0]           data_q;
  logic                 done_q;

  logic                 w_load;
  logic [c_CNT_W-1:0]   w_load_val;
  logic                 w_zero;
  logic                 w_accept;
  logic                 w_finish;
  logic                 w_poll_again;

  // This block only ever listens on the bus
  assign LCD_DATA = 8'bzzzz_zzzz;

  lcd_bus_timer #(
    .WIDTH (c_CNT_W)
  ) u_timer (
    .clk_i   (iClk),
    .rst_ni  (nRst),
    .load_i  (w_load),
    .value_i (w_load_val),
    .zero_o  (w_zero)
  );

  // State register
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; the phase counter is reloaded on every transition
  always_comb begin
    state_d    = state_q;
    w_load     = 1'b0;
    w_load_val = '0;
    w_accept   = 1'b0;
    w_finish   = 1'b0;
    case (state_q)
      IDLE: begin
        if (iStart) begin
          state_d    = SETUP;
          w_load     = 1'b1;
          w_load_val = c_LD_SETUP;
          w_accept   = 1'b1;
        end
      end
      SETUP: begin
        if (w_zero) begin
          state_d    = EN_HI;
          w_load     = 1'b1;
          w_load_val = c_LD_EN_HI;
        end
      end
      EN_HI: begin
        if (w_zero) begin
          state_d    = HOLD;
          w_load     = 1'b1;
          w_load_val = c_LD_HOLD;
        end
      end
      HOLD: begin
        if (w_zero) begin
          state_d    = RECOVER;
          w_load     = 1'b1;
          w_load_val = c_LD_RECOVER;
        end
      end
      RECOVER: begin
        if (w_zero) begin
          w_load = 1'b1;
          if (w_poll_again) begin
            state_d    = SETUP;
            w_load_val = c_LD_SETUP;
          end else begin
            state_d  = IDLE;
            w_finish = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        w_load  = 1'b1;
      end
    endcase
  end

  // Bus strobes and busy decode straight from state so reset drops them at once
  always_comb begin
    oBusy  = (state_q != IDLE);
    LCD_En = (state_q == EN_HI);
    LCD_RW = (state_q == SETUP) || (state_q == EN_HI) || (state_q == HOLD);
    LCD_RS = (state_q != IDLE) && rs_q;
  end

  // Latch RS on accept, sample the bus on the last En-high clock, pulse done
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      rs_q   <= 1'b0;
      data_q <= 8'h00;
      done_q <= 1'b0;
    end else begin
      done_q <= w_finish;
      if (w_accept) begin
        rs_q <= iRS;
      end
      if ((state_q == EN_HI) && w_zero) begin
        data_q <= LCD_DATA;
      end
    end
  end

  assign oDone = done_q;
  assign oData = data_q;

`ifdef LCD_BUSY_POLL_EN
  localparam int unsigned         c_POLL_W    = $clog2(MAX_POLLS + 1);
  localparam logic [c_POLL_W-1:0] c_POLL_LAST = c_POLL_W'(MAX_POLLS - 1);

  logic [c_POLL_W-1:0] poll_q;
  logic [c_POLL_W-1:0] poll_d;
  logic                timeout_q;
  logic                w_bf_set;
  logic                w_poll_limit;

  // poll_q counts reads already repeated; the current read is number poll_q+1
  assign w_bf_set     = !rs_q && data_q[LCD_BF_BIT];
  assign w_poll_again = w_bf_set && (poll_q < c_POLL_LAST);
  assign w_poll_limit = w_bf_set && !(poll_q < c_POLL_LAST);

  // Poll counter: cleared on accept, bumped on each repeat
  always_comb begin
    poll_d = poll_q;
    if (w_accept) begin
      poll_d = '0;
    end else if ((state_q == RECOVER) && w_zero && w_poll_again) begin
      poll_d = poll_q + 1'b1;
    end
  end

  // Poll counter and timeout pulse registers
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      poll_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      poll_q    <= poll_d;
      timeout_q <= w_finish && w_poll_limit;
    end
  end

  assign oTimeout = timeout_q;
`else
  assign w_poll_again = 1'b0;
  assign oTimeout     = 1'b0;
`endif

endmodule

`default_nettype wire
